// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared colour constants, sync idle level and a width helper
// Revision: 1.0
// ============================================================================
package vga_pkg;

    localparam int         RGB_W     = 3;
    localparam logic [1:0] SYNC_IDLE = 2'b11;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;

    // Bits needed to count 0..v-1, never less than one so a counter always exists.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_blink_timer.sv
`default_nettype none
// ============================================================================
// vga_blink_timer : counts frame ticks and toggles blink_phase every
//                   BLINK_FRAMES frames
// Revision: 1.0
// ============================================================================
module vga_blink_timer
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    output logic blink_phase
);

    localparam int            CW     = clog2(BLINK_FRAMES);
    localparam logic [CW-1:0] c_LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] count_q, count_d;
    logic          phase_q, phase_d;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (count_q == c_LAST) begin
                count_d = '0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/vga_layer_mixer.sv
`default_nettype none
// ============================================================================
// vga_layer_mixer : prioritised N-layer pixel compositor with blink, blanking
//                   and sync delay matched to the 2-cycle colour pipeline
// Revision: 1.0
// ============================================================================
module vga_layer_mixer #(
    parameter int         N_LAYERS     = 4,
    parameter int         RGB_W        = vga_pkg::RGB_W,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [1:0] SYNC_IDLE    = vga_pkg::SYNC_IDLE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      video_on,
    input  logic [1:0]                sync_in,
    input  logic                      frame_tick,
    input  logic [N_LAYERS-1:0]       layer_on,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       blink_en,
    input  logic [N_LAYERS-1:0]       layer_en,
    input  logic [RGB_W-1:0]          bg_rgb,
    output logic [RGB_W-1:0]          rgb,
    output logic [1:0]                sync_out,
    output logic                      blink_phase
);

    import vga_pkg::*;

    logic [N_LAYERS-1:0] eff;
    logic [RGB_W-1:0]    sel_d, sel_q;
    logic                vid_q;
    logic [1:0]          sync1_q;
    logic [RGB_W-1:0]    rgb_d, rgb_q;
    logic [1:0]          sync2_q;

    vga_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );

    always_comb begin
        eff = layer_on & layer_en & ~(blink_en & {N_LAYERS{blink_phase}});
    end

    // Walking from the lowest priority upward lets index 0 overwrite last.
    always_comb begin
        sel_d = bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                sel_d = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    always_comb begin
        rgb_d = vid_q ? sel_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            vid_q   <= 1'b0;
            sync1_q <= SYNC_IDLE;
            rgb_q   <= '0;
            sync2_q <= SYNC_IDLE;
        end else begin
            sel_q   <= sel_d;
            vid_q   <= video_on;
            sync1_q <= sync_in;
            rgb_q   <= rgb_d;
            sync2_q <= sync1_q;
        end
    end

    assign rgb      = rgb_q;
    assign sync_out = sync2_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_mixer.sv
`default_nettype none
// ============================================================================
// tb_vga_layer_mixer : directed stimulus with a cycle-tagged scoreboard
// Revision: 1.0
// ============================================================================
module tb_vga_layer_mixer;

    localparam int N = 4;
    localparam int W = 3;

    logic           clk;
    logic           reset;
    logic           video_on;
    logic [1:0]     sync_in;
    logic           frame_tick;
    logic [N-1:0]   layer_on;
    logic [N*W-1:0] layer_rgb;
    logic [N-1:0]   blink_en;
    logic [N-1:0]   layer_en;
    logic [W-1:0]   bg_rgb;
    logic [W-1:0]   rgb;
    logic [1:0]     sync_out;
    logic           blink_phase;

    vga_layer_mixer #(
        .N_LAYERS     (N),
        .RGB_W        (W),
        .BLINK_FRAMES (3),
        .SYNC_IDLE    (2'b11)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .sync_in     (sync_in),
        .frame_tick  (frame_tick),
        .layer_on    (layer_on),
        .layer_rgb   (layer_rgb),
        .blink_en    (blink_en),
        .layer_en    (layer_en),
        .bg_rgb      (bg_rgb),
        .rgb         (rgb),
        .sync_out    (sync_out),
        .blink_phase (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Scoreboard: target cycle, name, field mask {ph,sync,rgb}, value {ph,sync[1:0],rgb[2:0]}
    int         q_cyc[$];
    string      q_nm[$];
    logic [2:0] q_m[$];
    logic [5:0] q_v[$];

    task automatic expect_at(input int off, input string nm, input logic [2:0] m,
                             input logic [2:0] e_rgb, input logic [1:0] e_sync,
                             input logic e_ph);
        q_cyc.push_back(cyc + off);
        q_nm.push_back(nm);
        q_m.push_back(m);
        q_v.push_back({e_ph, e_sync, e_rgb});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Monitor: after every rising edge, compare all entries due this cycle.
    initial begin
        logic [5:0] v;
        logic [2:0] m;
        logic [2:0] e_rgb;
        logic [1:0] e_sync;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            for (int i = q_cyc.size() - 1; i >= 0; i--) begin
                if (q_cyc[i] == cyc) begin
                    v      = q_v[i];
                    m      = q_m[i];
                    e_rgb  = v[2:0];
                    e_sync = v[4:3];
                    if (m[0]) begin
                        checks = checks + 1;
                        if (rgb !== e_rgb) begin
                            errors = errors + 1;
                            $display("FAIL %s rgb got=%b exp=%b (cycle %0d)", q_nm[i], rgb, e_rgb, cyc);
                        end
                    end
                    if (m[1]) begin
                        checks = checks + 1;
                        if (sync_out !== e_sync) begin
                            errors = errors + 1;
                            $display("FAIL %s sync_out got=%b exp=%b (cycle %0d)", q_nm[i], sync_out, e_sync, cyc);
                        end
                    end
                    if (m[2]) begin
                        checks = checks + 1;
                        if (blink_phase !== v[5]) begin
                            errors = errors + 1;
                            $display("FAIL %s blink_phase got=%b exp=%b (cycle %0d)", q_nm[i], blink_phase, v[5], cyc);
                        end
                    end
                    q_cyc.delete(i);
                    q_nm.delete(i);
                    q_m.delete(i);
                    q_v.delete(i);
                end
            end
        end
    end

    logic [2:0] ph_after [6];
    logic [2:0] rgb_blink[6];

    initial begin
        ph_after  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
        rgb_blink = '{3'b111, 3'b111, 3'b111, 3'b010, 3'b010, 3'b010};

        // Reset held 3 cycles with busy inputs, including frame_tick.
        reset      = 1'b1;
        video_on   = 1'b1;
        sync_in    = 2'b00;
        frame_tick = 1'b1;
        layer_on   = 4'b1111;
        layer_rgb  = 12'hFFF;
        blink_en   = 4'b0000;
        layer_en   = 4'b1111;
        bg_rgb     = 3'b101;
        for (int k = 0; k < 3; k++) begin
            nxt();
            expect_at(1, "reset", 3'b111, 3'b000, 2'b11, 1'b0);
        end

        // Priority: layers 1 and 2 on, layer 1 wins.
        nxt();
        reset      = 1'b0;
        frame_tick = 1'b0;
        layer_on   = 4'b0110;
        layer_rgb  = {3'b011, 3'b010, 3'b100, 3'b111};
        sync_in    = 2'b10;
        expect_at(1, "post_reset_gap", 3'b011, 3'b000, 2'b11, 1'b0);
        expect_at(2, "priority", 3'b011, 3'b100, 2'b10, 1'b0);

        nxt();
        layer_on = 4'b0000;
        bg_rgb   = 3'b001;
        expect_at(2, "background", 3'b001, 3'b001, 2'b00, 1'b0);

        // Blanking follows delayed video_on.
        nxt();
        layer_on = 4'b0001;
        sync_in  = 2'b01;
        expect_at(2, "blank_on1", 3'b011, 3'b111, 2'b01, 1'b0);
        nxt();
        video_on = 1'b0;
        expect_at(2, "blank_off", 3'b001, 3'b000, 2'b00, 1'b0);
        nxt();
        video_on = 1'b1;
        expect_at(2, "blank_on2", 3'b001, 3'b111, 2'b00, 1'b0);

        // Static mask.
        nxt();
        layer_en = 4'b1110;
        expect_at(2, "mask_bg", 3'b001, 3'b001, 2'b00, 1'b0);
        nxt();
        layer_on = 4'b0011;
        expect_at(2, "mask_next", 3'b001, 3'b100, 2'b00, 1'b0);

        // Blink with BLINK_FRAMES = 3 on layer 0.
        nxt();
        layer_en  = 4'b1111;
        blink_en  = 4'b0001;
        layer_rgb = {3'b011, 3'b001, 3'b010, 3'b111};
        for (int k = 0; k < 6; k++) begin
            nxt();
            frame_tick = 1'b1;
            expect_at(1, "blink_phase", 3'b100, 3'b000, 2'b00, ph_after[k][0]);
            expect_at(2, "blink_rgb", 3'b001, rgb_blink[k], 2'b00, 1'b0);
        end
        nxt();
        frame_tick = 1'b0;
        expect_at(2, "blink_back", 3'b101, 3'b111, 2'b00, 1'b0);

        // Four more ticks: phase 1 with count 1, then reset together with frame_tick.
        for (int k = 0; k < 4; k++) begin
            nxt();
            frame_tick = 1'b1;
        end
        expect_at(1, "pre_reset_phase", 3'b100, 3'b000, 2'b00, 1'b1);
        nxt();
        reset = 1'b1;
        expect_at(1, "reset_with_tick", 3'b111, 3'b000, 2'b11, 1'b0);
        for (int k = 0; k < 3; k++) begin
            nxt();
            reset = 1'b0;
            expect_at(1, "count_restart", 3'b100, 3'b000, 2'b00, (k == 2) ? 1'b1 : 1'b0);
        end
        nxt();
        frame_tick = 1'b0;

        repeat (4) nxt();
        checks = checks + 1;
        if (q_cyc.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d exp=0", q_cyc.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Pixel-colour compositor between the text/graphics generators and the VGA DAC pins.
- Takes N_LAYERS per-pixel "on" flags, each with its own colour, plus a background colour. Picks the highest-priority active layer, applies per-layer blinking and blanking, and registers the result.
- Delays the sync signals by the same latency so colour and sync stay aligned at the connector.
- Generalises the single-colour on/off gate to N prioritised layers with blink and background.

Parameters:
- N_LAYERS, 4, number of overlay layers; index 0 has the highest priority.
- RGB_W, 3, colour width per pixel.
- BLINK_FRAMES, 30, frames per blink half-period; legal range ≥ 1.
- SYNC_IDLE, 2'b11, reset value of sync_out; the syncs are active-low.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- video_on  in  1  visible-area flag from the sync generator
- sync_in  in  2  {hsync, vsync} from the sync generator
- frame_tick  in  1  one-cycle pulse, once per frame
- layer_on  in  N_LAYERS  per-layer pixel-active flags
- layer_rgb  in  N_LAYERS*RGB_W  layer i colour at bits [i*RGB_W +: RGB_W]
- blink_en  in  N_LAYERS  layer blinks when its bit is set
- layer_en  in  N_LAYERS  static layer mask; 0 disables the layer
- bg_rgb  in  RGB_W  colour used when no layer is active
- rgb  out  RGB_W  registered pixel colour
- sync_out  out  2  sync_in delayed to match rgb
- blink_phase  out  1  current blink phase, for status/debug

Behaviour:
- Reset is synchronous and active-high, sampled on the rising clk edge. Reset values:
  - rgb = 0
  - sync_out = SYNC_IDLE
  - blink_phase = 0
  - frame counter = 0
  - all pipeline registers cleared; the video_on pipe clears to 0
- Latency is 2 clk, fixed:
  - Stage 1 registers the selected colour, the video_on stage-1 copy and the sync_in stage-1 copy.
  - Stage 2 registers rgb and sync_out.
  - A change on the inputs at cycle n appears on rgb/sync_out at cycle n+2.
- Effective layer: eff[i] = layer_on[i] & layer_en[i] & ~(blink_en[i] & blink_phase).
  - blink_phase is sampled in the same cycle as the layer inputs.
- Priority:
  - Selected colour = layer_rgb of the lowest index i with eff[i] = 1.
  - If no eff bit is set, selected colour = bg_rgb.
- Blanking:
  - If the stage-1 video_on copy is 0, the stage-2 rgb is 0, regardless of layers or bg.
  - Blanking follows the delayed video_on, so it stays aligned with the colour.
- Blink counter:
  - Counter width is clog2(BLINK_FRAMES), minimum 1 bit.
  - On frame_tick: if count == BLINK_FRAMES-1, count goes to 0 and blink_phase toggles; otherwise count increments.
  - Without frame_tick the counter holds.
  - With BLINK_FRAMES = 1, blink_phase toggles on every frame_tick.
- blink_phase changes only on frame_tick. Layer on/off therefore never changes mid-frame because of blinking.
- If frame_tick and reset are asserted together, reset wins.
- If reset is asserted mid-frame, the outputs go to their reset values on the next edge. Two cycles after reset deasserts, valid pipelined data appears again.
- No combinational path from any input to rgb or sync_out.

Decomposition:
- Shared package vga_pkg holds:
  - RGB_W default
  - colour constants: BLACK = 3'b000, WHITE = 3'b111, RED = 3'b100, GREEN = 3'b010, BLUE = 3'b001
  - SYNC_IDLE
  - a clog2 function
- Sub-module vga_blink_timer: frame counter plus blink_phase toggle, parameter BLINK_FRAMES. Instantiated once.
- Priority select stays inline as a for-loop from high index down to 0.

Test Plan:
- Reset: assert reset 3 cycles with arbitrary inputs -> rgb = 000, sync_out = 11, blink_phase = 0 on each cycle; first valid rgb appears 2 cycles after reset release.
- Priority: video_on = 1, layer_en = 1111, layer_on = 0110, layer1 = 100, layer2 = 010 -> rgb = 100 at n+2. Then layer_on = 0000, bg_rgb = 001 -> rgb = 001.
- Blanking alignment: layer_on = 0001, layer0 = 111, video_on toggled 1,0,1 on consecutive cycles -> rgb = 111,000,111 delayed by 2; sync_in = 01 -> sync_out = 01 at n+2.
- Blink, BLINK_FRAMES = 3: blink_en = 0001, layer_on = 0011, layer0 = 111, layer1 = 010.
  - Frame_ticks 1-2 -> rgb = 111.
  - After the 3rd tick, blink_phase = 1 and rgb = 010.
  - After the 6th tick -> rgb = 111.
- Mask: layer_en = 1110, layer_on = 0001, layer0 = 111 -> rgb = bg_rgb; frame_tick asserted together with reset -> counter stays 0.
